// File: rtl/tcdm_bank_resp.sv
// Single-bank TCDM memory with registered response port and an atomic
// read-modify-write unit (add / swap). Requests arrive packed as
// {op[1:0], be, addr, wdata}. Reads and writes sustain one grant per cycle.
// Atomics read the old word in the grant cycle, then spend one extra cycle
// (AMO_WR) writing the result back, so they sustain one grant per two cycles.
module tcdm_bank_resp #(
  parameter int unsigned NumWords     = 256,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = $clog2(NumWords),
  parameter int unsigned ReqDataWidth = 2 + DataWidth/8 + AddrWidth + DataWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ReqDataWidth-1:0] data_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    rvalid_o,
  input  logic                    busy_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE    = 2'b01,
    OP_AMO_ADD  = 2'b10,
    OP_AMO_SWAP = 2'b11
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    AMO_WR = 1'b1
  } state_e;

  state_e               state_q;
  logic [DataWidth-1:0] mem [NumWords];

  // Response registers
  logic [DataWidth-1:0] rdata_q;
  logic                 rvalid_q;

  // Atomic operands captured at grant, consumed in AMO_WR
  op_e                  amo_op_q;
  logic [BeWidth-1:0]   amo_be_q;
  logic [AddrWidth-1:0] amo_addr_q;
  logic [DataWidth-1:0] amo_wdata_q;

  // Unpacked request fields
  op_e                  req_op;
  logic [BeWidth-1:0]   req_be;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 handshake;

  // Single memory write port, shared by plain writes and the AMO write-back
  logic                 wr_en;
  logic [AddrWidth-1:0] wr_addr;
  logic [BeWidth-1:0]   wr_be;
  logic [DataWidth-1:0] wr_data;

  assign req_wdata = data_i[DataWidth-1:0];
  assign req_addr  = data_i[DataWidth +: AddrWidth];
  assign req_be    = data_i[DataWidth+AddrWidth +: BeWidth];
  assign req_op    = op_e'(data_i[ReqDataWidth-1 -: 2]);

  // While in reset the bank looks idle to the interconnect, so the grant
  // follows busy_i alone; nothing granted during reset takes effect.
  assign gnt_o     = ~busy_i & ((state_q == IDLE) | ~rst_ni);
  assign handshake = req_i & gnt_o & rst_ni;

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;

  // Select the source of this cycle's memory write (AMO write-back wins; no
  // grant can coincide with it since gnt_o is low in AMO_WR)
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_en   = 1'b0;
    wr_addr = req_addr;
    wr_be   = req_be;
    wr_data = req_wdata;
    if (rst_ni) begin
      if (state_q == AMO_WR) begin
        wr_en   = 1'b1;
        wr_addr = amo_addr_q;
        wr_be   = amo_be_q;
        // rdata_q still holds the old word returned for this atomic.
        wr_data = (amo_op_q == OP_AMO_ADD) ? rdata_q + amo_wdata_q : amo_wdata_q;
      end else if (handshake && req_op == OP_WRITE) begin
        wr_en = 1'b1;
      end
    end
  end

  // Byte-enabled memory write
  // NOTE: the storage array has no reset; contents survive rst_ni, and a
  // reset branch here would turn the array into flops instead of RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // FSM, atomic operand capture and registered response
  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= handshake;
      rdata_q  <= '0;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            case (req_op)
              OP_READ:  rdata_q <= mem[req_addr];
              OP_WRITE: rdata_q <= '0;
              default: begin
                rdata_q     <= mem[req_addr];
                amo_op_q    <= req_op;
                amo_be_q    <= req_be;
                amo_addr_q  <= req_addr;
                amo_wdata_q <= req_wdata;
                state_q     <= AMO_WR;
              end
            endcase
          end
        end
        AMO_WR:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcdm_bank_resp.sv
// Self-checking bench for tcdm_bank_resp. A behavioural model of the bank
// (memory, grant rule, pending atomic) predicts each response; predictions
// are queued at grant and popped when the response cycle is sampled.
module tb_tcdm_bank_resp;

  localparam int unsigned NumWords  = 256;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 8;
  localparam int unsigned ReqW      = 2 + DataWidth/8 + AddrWidth + DataWidth;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ADD = 2'b10, SWP = 2'b11;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 req_i;
  logic                 gnt_o;
  logic [ReqW-1:0]      data_i;
  logic [DataWidth-1:0] rdata_o;
  logic                 rvalid_o;
  logic                 busy_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_mem [NumWords];
  logic        m_amo = 1'b0;
  logic [1:0]  m_op;
  logic [3:0]  m_be;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_old;
  logic [31:0] sb [$];

  tcdm_bank_resp #(
    .NumWords (NumWords),
    .DataWidth(DataWidth)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .data_i  (data_i),
    .rdata_o (rdata_o),
    .rvalid_o(rvalid_o),
    .busy_i  (busy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // One clock cycle: drive at posedge+1, check grant at negedge, advance the
  // model at the edge, check the response at posedge+1.
  task automatic step(input logic rst, input logic req, input logic busy, input logic [1:0] op,
                      input logic [3:0] be, input logic [7:0] addr, input logic [31:0] wdata);
    logic        exp_gnt, granted;
    logic [31:0] exp_rdata;
    rst_ni = rst;
    req_i  = req;
    busy_i = busy;
    data_i = {op, be, addr, wdata};
    #4;
    exp_gnt = !busy && (!m_amo || !rst);
    tests_run++;
    if (gnt_o !== exp_gnt) begin
      tests_failed++;
      $display("FAIL gnt t=%0t: got %b want %b", $time, gnt_o, exp_gnt);
    end
    @(posedge clk_i);
    granted = rst && req && exp_gnt;
    if (!rst) begin
      m_amo = 1'b0;
    end else begin
      if (m_amo) begin
        model_write(m_addr, m_be, (m_op == ADD) ? m_old + m_wdata : m_wdata);
        m_amo = 1'b0;
      end
      if (granted) begin
        case (op)
          RD: sb.push_back(m_mem[addr]);
          WR: begin sb.push_back(32'h0); model_write(addr, be, wdata); end
          default: begin
            sb.push_back(m_mem[addr]);
            m_old = m_mem[addr]; m_amo = 1'b1;
            m_op = op; m_be = be; m_addr = addr; m_wdata = wdata;
          end
        endcase
      end
    end
    #1;
    tests_run++;
    if (rvalid_o !== granted) begin
      tests_failed++;
      $display("FAIL rvalid t=%0t: got %b want %b", $time, rvalid_o, granted);
    end
    if (granted) exp_rdata = sb.pop_front();
    else         exp_rdata = 32'h0;
    tests_run++;
    if (rdata_o !== exp_rdata) begin
      tests_failed++;
      $display("FAIL rdata t=%0t: got %h want %h", $time, rdata_o, exp_rdata);
    end
  endtask

  task automatic idle_cycle();
    step(1'b1, 1'b0, 1'b0, RD, 4'h0, 8'h0, 32'h0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, RD, 4'h0, 8'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, WR, 4'hF, 8'h4, 32'h1234_5678);
    // a "write" offered during reset must not land
    step(1'b0, 1'b1, 1'b0, WR, 4'hF, 8'h4, 32'h1234_5678);
    tests_run++;
    if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: rvalid %b rdata %h want 0/0", rvalid_o, rdata_o);
    end
    step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'h4, 32'hCAFE_0004);
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'h4, 32'h0);
    tests_run++;
    if (rdata_o !== 32'hCAFE_0004) begin
      tests_failed++;
      $display("FAIL reset_no_write: got %h want cafe0004", rdata_o);
    end
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'd5, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd5, 32'h0);
    tests_run++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_read: rvalid %b rdata %h want 1/deadbeef", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_byte_enable();
    step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'd7, 32'h1122_3344);
    step(1'b1, 1'b1, 1'b0, WR, 4'b0010, 8'd7, 32'hAABB_CCDD);
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd7, 32'h0);
    tests_run++;
    if (rdata_o !== 32'h1122_CC44) begin
      tests_failed++;
      $display("FAIL byte_enable: got %h want 1122cc44", rdata_o);
    end
    // be=0 write still responds but leaves the word alone
    step(1'b1, 1'b1, 1'b0, WR, 4'b0000, 8'd7, 32'h5555_5555);
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd7, 32'h0);
    tests_run++;
    if (rdata_o !== 32'h1122_CC44) begin
      tests_failed++;
      $display("FAIL be_zero: got %h want 1122cc44", rdata_o);
    end
  endtask

  task automatic test_amo_add();
    step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'd3, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, ADD, 4'hF, 8'd3, 32'h2);
    tests_run++;
    if (rdata_o !== 32'hFFFF_FFFF || gnt_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL amo_add_resp: rdata %h gnt %b want ffffffff/0", rdata_o, gnt_o);
    end
    // AMO_WR cycle with busy asserted: write-back must still happen
    step(1'b1, 1'b1, 1'b1, RD, 4'h0, 8'd3, 32'h0);
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd3, 32'h0);
    tests_run++;
    if (rdata_o !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL amo_add_result: got %h want 00000001", rdata_o);
    end
  endtask

  task automatic test_amo_swap();
    step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'd10, 32'h0BAD_F00D);
    step(1'b1, 1'b1, 1'b0, SWP, 4'b1100, 8'd10, 32'h1357_9BDF);
    // AMO_WR with a read offered: not granted; read retried right after
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd10, 32'h0);
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd10, 32'h0);
    tests_run++;
    if (rdata_o !== 32'h1357_F00D) begin
      tests_failed++;
      $display("FAIL amo_swap_result: got %h want 1357f00d", rdata_o);
    end
    // back-to-back atomics: one grant per two cycles
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, ADD, 4'hF, 8'd11, 32'h10);
  endtask

  task automatic test_busy();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, RD, 4'h0, 8'd5, 32'h0);
      tests_run++;
      if (gnt_o !== 1'b0 || rvalid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_stall: gnt %b rvalid %b want 0/0", gnt_o, rvalid_o);
      end
    end
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd5, 32'h0);
    tests_run++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL busy_release: rvalid %b rdata %h want 1/deadbeef", rvalid_o, rdata_o);
    end
  endtask

  task automatic test_amo_reset_abort();
    step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'd9, 32'h5);
    step(1'b1, 1'b1, 1'b0, SWP, 4'hF, 8'd9, 32'hFFFF_0000);
    step(1'b0, 1'b0, 1'b0, RD, 4'h0, 8'd0, 32'h0);
    tests_run++;
    if (rvalid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_rvalid: got %b want 0", rvalid_o);
    end
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd9, 32'h0);
    tests_run++;
    if (rdata_o !== 32'h5) begin
      tests_failed++;
      $display("FAIL abort_mem: got %h want 00000005", rdata_o);
    end
  endtask

  task automatic test_idle();
    // request data is ignored without req_i
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, 2'($urandom_range(3)), 4'hF, 8'd5, $urandom);
    step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'd5, 32'h0);
    tests_run++;
    if (rdata_o !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL idle_ignore: got %h want deadbeef", rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'(i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, RD, 4'h0, 8'(i), 32'h0);
      tests_run++;
      if (rvalid_o !== 1'b1 || rdata_o !== 32'hA000_0000 + 32'(i)) begin
        tests_failed++;
        $display("FAIL b2b_read[%0d]: rvalid %b rdata %h want 1/%h", i, rvalid_o, rdata_o,
                 32'hA000_0000 + 32'(i));
      end
    end
    // mixed random read/write stream
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b1, 1'($urandom_range(1) & ($urandom_range(3) == 0)), 2'($urandom_range(1)),
           4'($urandom), 8'($urandom_range(15) + 32), $urandom);
    idle_cycle();
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i  = 1'b0;
    busy_i = 1'b0;
    data_i = '0;
    for (int i = 0; i < int'(NumWords); i++) m_mem[i] = 32'h0;
    // initialise the random-stream region so model and DUT agree
    @(posedge clk_i);
    #1;
    test_reset();
    for (int i = 32; i < 48; i++) step(1'b1, 1'b1, 1'b0, WR, 4'hF, 8'(i), 32'(i) * 32'h0101_0101);
    test_write_read();
    test_byte_enable();
    test_amo_add();
    test_amo_swap();
    test_busy();
    test_amo_reset_abort();
    test_idle();
    test_back_to_back();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
